// File: rtl/uart_rx_deser_param_if.sv
// uart_rx_deser_param_if: bundle between the RX front end (master) and the deserializer (slave)
//   master drives: frame_start_se, deser_en_se, sampled_bit_se, edge_count_se, prescale_se, data_len_se
//   slave drives:  p_data_se, p_data_vld_se, busy_se, bit_cnt_se, len_err_se
interface uart_rx_deser_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
);
    logic                  frame_start_se;
    logic                  deser_en_se;
    logic                  sampled_bit_se;
    logic [PRESCALE_W-1:0] edge_count_se;
    logic [PRESCALE_W-1:0] prescale_se;
    logic [LEN_W-1:0]      data_len_se;
    logic [DATA_WIDTH-1:0] p_data_se;
    logic                  p_data_vld_se;
    logic                  busy_se;
    logic [LEN_W-1:0]      bit_cnt_se;
    logic                  len_err_se;
    modport master (
        output frame_start_se, deser_en_se, sampled_bit_se, edge_count_se, prescale_se, data_len_se,
        input  p_data_se, p_data_vld_se, busy_se, bit_cnt_se, len_err_se
    );
    modport slave (
        input  frame_start_se, deser_en_se, sampled_bit_se, edge_count_se, prescale_se, data_len_se,
        output p_data_se, p_data_vld_se, busy_se, bit_cnt_se, len_err_se
    );
endinterface

// File: rtl/uart_rx_deser_param.sv
// uart_rx_deser_param: collects oversampled UART data bits into a runtime-length word
//   clk_se, rst_se : clock and synchronous active-high reset
//   s (slave)      : frame control and sampled bit in; completed word, valid pulse, status out
module uart_rx_deser_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int MSB_FIRST  = 0,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input logic                  clk_se,
    input logic                  rst_se,
    uart_rx_deser_param_if.slave s
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d, len_q, len_d, idx;
    logic                  vld_q, vld_d, err_q, err_d, capture, len_ok, last;
    // prescale below 2 has no valid sample point, so it never captures
    assign capture = s.deser_en_se && state_q == SHIFT && s.prescale_se > PRESCALE_W'(1)
                     && s.edge_count_se == s.prescale_se - PRESCALE_W'(1);
    assign len_ok  = s.data_len_se != '0 && s.data_len_se <= LEN_W'(DATA_WIDTH);
    assign idx     = MSB_FIRST != 0 ? len_q - cnt_q - LEN_W'(1) : cnt_q;
    assign last    = cnt_q == len_q - LEN_W'(1);
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        pdata_d = pdata_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        // frame_start has priority: it aborts any partial frame and drops a coincident capture
        if (s.frame_start_se) begin
            state_d = len_ok ? SHIFT : IDLE;
            shift_d = '0;
            cnt_d   = '0;
            len_d   = len_ok ? s.data_len_se : len_q;
            err_d   = err_q | ~len_ok;
        end else if (capture) begin
            // shift reg is cleared at frame start, so OR-ing in each bit leaves unused positions zero
            shift_d = shift_q | (DATA_WIDTH'(s.sampled_bit_se) << idx);
            cnt_d   = last ? '0 : cnt_q + LEN_W'(1);
            state_d = last ? IDLE : SHIFT;
            pdata_d = last ? shift_d : pdata_q;
            vld_d   = last;
        end
    end
    always_ff @(posedge clk_se) begin
        if (rst_se) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            pdata_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pdata_q <= pdata_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end
    assign s.p_data_se     = pdata_q;
    assign s.p_data_vld_se = vld_q;
    assign s.busy_se       = state_q == SHIFT;
    assign s.bit_cnt_se    = cnt_q;
    assign s.len_err_se    = err_q;
endmodule

// File: tb/tb_uart_rx_deser_param.sv
// tb_uart_rx_deser_param: directed checks of LSB-first and MSB-first deserializer instances
module tb_uart_rx_deser_param;
    logic clk, rst;
    int   n_pass, n_total, v0, v1;
    uart_rx_deser_param_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) if0 ();
    uart_rx_deser_param_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) if1 ();
    assign if1.frame_start_se = if0.frame_start_se;
    assign if1.deser_en_se    = if0.deser_en_se;
    assign if1.sampled_bit_se = if0.sampled_bit_se;
    assign if1.edge_count_se  = if0.edge_count_se;
    assign if1.prescale_se    = if0.prescale_se;
    assign if1.data_len_se    = if0.data_len_se;
    uart_rx_deser_param #(.DATA_WIDTH(8), .PRESCALE_W(6), .MSB_FIRST(0)) u_lsb (
        .clk_se(clk), .rst_se(rst), .s(if0.slave));
    uart_rx_deser_param #(.DATA_WIDTH(8), .PRESCALE_W(6), .MSB_FIRST(1)) u_msb (
        .clk_se(clk), .rst_se(rst), .s(if1.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        if (if0.p_data_vld_se) v0++;
        if (if1.p_data_vld_se) v1++;
    endtask
    task automatic start(input logic [3:0] len);
        if0.data_len_se    = len;
        if0.frame_start_se = 1'b1;
        tick();
        if0.frame_start_se = 1'b0;
    endtask
    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            if0.deser_en_se = 1'b0;
            for (int e = 0; e < 8; e++) begin
                if0.edge_count_se = 6'(e);
                tick();
            end
        end
        if0.deser_en_se    = 1'b1;
        if0.sampled_bit_se = b;
        for (int e = 0; e < 8; e++) begin
            if0.edge_count_se = 6'(e);
            tick();
        end
        if0.deser_en_se   = 1'b0;
        if0.edge_count_se = '0;
    endtask
    task automatic frame(input logic [3:0] len, input logic [7:0] seq, input logic [7:0] gaps);
        start(len);
        if0.data_len_se = 4'd3;
        for (int i = 0; i < int'(len); i++) send_bit(seq[i], gaps[i]);
    endtask
    initial begin
        n_pass = 0; n_total = 0; v0 = 0; v1 = 0;
        rst = 1'b1;
        if0.frame_start_se = 1'b0; if0.deser_en_se = 1'b0; if0.sampled_bit_se = 1'b0;
        if0.edge_count_se = '0; if0.prescale_se = 6'd8; if0.data_len_se = 4'd8;
        tick(); tick();
        rst = 1'b0;
        check("rst_pdata", 32'(if0.p_data_se), 32'h0);
        check("rst_vld", 32'(if0.p_data_vld_se), 32'h0);
        check("rst_busy", 32'(if0.busy_se), 32'h0);
        check("rst_cnt", 32'(if0.bit_cnt_se), 32'h0);
        check("rst_err", 32'(if0.len_err_se), 32'h0);
        // T1 / T2 (len 8): 1,0,1,1,0,0,1,0
        v0 = 0; v1 = 0;
        frame(4'd8, 8'b0100_1101, 8'h00);
        check("t1_vld_lat", 32'(if0.p_data_vld_se), 32'h1);
        check("t1_pdata_lsb", 32'(if0.p_data_se), 32'h4D);
        check("t2_pdata_msb", 32'(if1.p_data_se), 32'hB2);
        check("t1_busy", 32'(if0.busy_se), 32'h0);
        check("t1_cnt", 32'(if0.bit_cnt_se), 32'h0);
        tick();
        check("t1_vld_low", 32'(if0.p_data_vld_se), 32'h0);
        check("t1_hold", 32'(if0.p_data_se), 32'h4D);
        check("t1_vcount", 32'(v0), 32'h1);
        check("t2_vcount", 32'(v1), 32'h1);
        // T2 len 5: 1,0,1,1,1
        frame(4'd5, 8'b0001_1101, 8'h00);
        check("t2_len5_msb", 32'(if1.p_data_se), 32'h17);
        check("t2_len5_lsb", 32'(if0.p_data_se), 32'h1D);
        // T3 len 5: 1,1,0,0,1 with bit_cnt tracking
        start(4'd5);
        check("t3_cnt0", 32'(if0.bit_cnt_se), 32'h0);
        for (int i = 0; i < 5; i++) begin
            send_bit(8'b0001_0011 >> i, 1'b0);
            check($sformatf("t3_cnt%0d", i + 1), 32'(if0.bit_cnt_se), (i == 4) ? 32'h0 : 32'(i + 1));
        end
        check("t3_pdata_lsb", 32'(if0.p_data_se), 32'h13);
        check("t3_upper0", 32'(if0.p_data_se[7:5]), 32'h0);
        check("t3_pdata_msb", 32'(if1.p_data_se), 32'h19);
        // T4: abort after 3 captures, coincident capture dropped, then 0xA5
        v0 = 0; v1 = 0;
        start(4'd8);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        check("t4_cnt3", 32'(if0.bit_cnt_se), 32'h3);
        if0.deser_en_se = 1'b1; if0.sampled_bit_se = 1'b1; if0.edge_count_se = 6'd7;
        if0.data_len_se = 4'd8; if0.frame_start_se = 1'b1;
        tick();
        if0.frame_start_se = 1'b0; if0.deser_en_se = 1'b0; if0.edge_count_se = '0;
        check("t4_restart_cnt", 32'(if0.bit_cnt_se), 32'h0);
        check("t4_restart_busy", 32'(if0.busy_se), 32'h1);
        check("t4_no_vld", 32'(v0), 32'h0);
        for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i, 1'b0);
        tick();
        check("t4_vcount", 32'(v0), 32'h1);
        check("t4_pdata_lsb", 32'(if0.p_data_se), 32'hA5);
        check("t4_pdata_msb", 32'(if1.p_data_se), 32'hA5);
        // T5: illegal lengths and prescale below 2
        v0 = 0;
        start(4'd0);
        check("t5_err_len0", 32'(if0.len_err_se), 32'h1);
        check("t5_busy_len0", 32'(if0.busy_se), 32'h0);
        send_bit(1'b1, 1'b0);
        check("t5_idle_cnt", 32'(if0.bit_cnt_se), 32'h0);
        check("t5_idle_vld", 32'(v0), 32'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_err_clr", 32'(if0.len_err_se), 32'h0);
        start(4'd9);
        check("t5_err_len9", 32'(if0.len_err_se), 32'h1);
        check("t5_busy_len9", 32'(if0.busy_se), 32'h0);
        if0.prescale_se = 6'd1;
        start(4'd8);
        check("t5_busy_ok", 32'(if0.busy_se), 32'h1);
        if0.deser_en_se = 1'b1; if0.sampled_bit_se = 1'b1; if0.edge_count_se = '0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_pre1_cnt", 32'(if0.bit_cnt_se), 32'h0);
        if0.prescale_se = 6'd0; if0.edge_count_se = 6'd63;
        tick();
        check("t5_pre0_cnt", 32'(if0.bit_cnt_se), 32'h0);
        if0.prescale_se = 6'd8; if0.deser_en_se = 1'b0; if0.edge_count_se = '0;
        check("t5_err_sticky", 32'(if0.len_err_se), 32'h1);
        // T6: reset on the 4th capture, then 0x3C with enable gaps
        start(4'd8);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        if0.deser_en_se = 1'b1;
        for (int e = 0; e < 7; e++) begin
            if0.edge_count_se = 6'(e);
            tick();
        end
        if0.edge_count_se = 6'd7; rst = 1'b1;
        tick();
        rst = 1'b0; if0.deser_en_se = 1'b0; if0.edge_count_se = '0;
        check("t6_pdata", 32'(if0.p_data_se), 32'h0);
        check("t6_pdata_msb", 32'(if1.p_data_se), 32'h0);
        check("t6_vld", 32'(if0.p_data_vld_se), 32'h0);
        check("t6_busy", 32'(if0.busy_se), 32'h0);
        check("t6_cnt", 32'(if0.bit_cnt_se), 32'h0);
        check("t6_err", 32'(if0.len_err_se), 32'h0);
        v0 = 0; v1 = 0;
        frame(4'd8, 8'h3C, 8'b0010_0110);
        tick();
        check("t6_vcount", 32'(v0), 32'h1);
        check("t6_pdata_lsb", 32'(if0.p_data_se), 32'h3C);
        check("t6_pdata_msb", 32'(if1.p_data_se), 32'h3C);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
